// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the CPU phase sequencer: state codes, op-class
// codes and the sizing helper for the fetch/memory wait counter.
package cpu_seq_pkg;

   // Sequencer state codes (also driven out on the debug state port)
   localparam logic [3:0] ST_IDLE   = 4'd0;
   localparam logic [3:0] ST_FETCH  = 4'd1;
   localparam logic [3:0] ST_FWAIT  = 4'd2;
   localparam logic [3:0] ST_DECODE = 4'd3;
   localparam logic [3:0] ST_EXEC   = 4'd4;
   localparam logic [3:0] ST_MEM    = 4'd5;
   localparam logic [3:0] ST_MWAIT  = 4'd6;
   localparam logic [3:0] ST_WB     = 4'd7;
   localparam logic [3:0] ST_HALT   = 4'd8;

   // Decoded instruction classes
   localparam logic [2:0] OP_ALU    = 3'd0;
   localparam logic [2:0] OP_LOAD   = 3'd1;
   localparam logic [2:0] OP_STORE  = 3'd2;
   localparam logic [2:0] OP_BRANCH = 3'd3;
   localparam logic [2:0] OP_JUMP   = 3'd4;
   localparam logic [2:0] OP_JAL    = 3'd5;
   localparam logic [2:0] OP_JR     = 3'd6;
   localparam logic [2:0] OP_HALT   = 3'd7;

   // The counter must hold the larger of the two latencies. At least one
   // bit is kept so a build with both latencies at zero still elaborates.
   function automatic int wait_cnt_width(input int rom_lat, input int ram_lat);
      int max_lat;
      max_lat = (rom_lat > ram_lat) ? rom_lat : ram_lat;
      if (max_lat < 1) return 1;
      return $clog2(max_lat + 1);
   endfunction

endpackage

// File: rtl/seq_wait_counter.sv
// Load/decrement down-counter used for both the ROM (FWAIT) and RAM (MWAIT)
// wait states. o_done flags the last wait cycle so the FSM can move on.
module seq_wait_counter #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_dec,
   output logic         o_done
);

   logic [W-1:0] r_count;

   // Load takes priority over decrement; the count never wraps below zero
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - W'(1);
      end
   end

   // A count of one means this is the final wait cycle
   assign o_done = (r_count <= W'(1));

endmodule

// File: rtl/cpu_phase_sequencer.sv
// Multi-cycle phase sequencer for the single-issue CPU. Walks each
// instruction through fetch/decode/execute/memory/writeback, emits the
// one-cycle datapath strobes and inserts ROM/RAM wait states.
module cpu_phase_sequencer
   import cpu_seq_pkg::*;
#(
   parameter int ROM_LAT = 1,
   parameter int RAM_LAT = 1,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic             step,
   input  logic [2:0]       op_class,
   input  logic             branch_taken,
   output logic             fetch_en,
   output logic             ir_load,
   output logic             pc_increment,
   output logic             pc_load,
   output logic             reg_write_enable,
   output logic             mem_to_reg,
   output logic             ram_read_enable,
   output logic             ram_write_enable,
   output logic             busy,
   output logic             halted,
   output logic [3:0]       state,
   output logic [CNT_W-1:0] instr_count
);

   localparam int                WAIT_W    = wait_cnt_width(ROM_LAT, RAM_LAT);
   localparam logic [WAIT_W-1:0] ROM_LAT_W = WAIT_W'(ROM_LAT);
   localparam logic [WAIT_W-1:0] RAM_LAT_W = WAIT_W'(RAM_LAT);

   logic [3:0]        r_state;
   logic [2:0]        r_op_q;
   logic [CNT_W-1:0]  r_instr_count;

   logic [3:0]        w_state_next;
   logic              w_retire;
   logic              w_wait_load;
   logic              w_wait_dec;
   logic              w_wait_done;
   logic [WAIT_W-1:0] w_wait_val;

   // FETCH loads the ROM latency, MEM loads the RAM latency
   assign w_wait_val = (r_state == ST_MEM) ? RAM_LAT_W : ROM_LAT_W;

   seq_wait_counter #(
      .W (WAIT_W)
   ) u_wait (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_wait_load),
      .i_load_val (w_wait_val),
      .i_dec      (w_wait_dec),
      .o_done     (w_wait_done)
   );

   // Next-state and strobe decode; strobes come from the state register and
   // op_q, except in EXEC where the live op_class/branch_taken are used
   always_comb begin
      w_state_next     = r_state;
      w_retire         = 1'b0;
      w_wait_load      = 1'b0;
      w_wait_dec       = 1'b0;
      fetch_en         = 1'b0;
      ir_load          = 1'b0;
      pc_increment     = 1'b0;
      pc_load          = 1'b0;
      reg_write_enable = 1'b0;
      mem_to_reg       = 1'b0;
      ram_read_enable  = 1'b0;
      ram_write_enable = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (run) w_state_next = ST_FETCH;
         end
         ST_FETCH: begin
            fetch_en = 1'b1;
            if (ROM_LAT == 0) begin
               w_state_next = ST_DECODE;
            end else begin
               w_state_next = ST_FWAIT;
               w_wait_load  = 1'b1;
            end
         end
         ST_FWAIT: begin
            w_wait_dec = 1'b1;
            if (w_wait_done) w_state_next = ST_DECODE;
         end
         ST_DECODE: begin
            ir_load      = 1'b1;
            w_state_next = ST_EXEC;
         end
         ST_EXEC: begin
            case (op_class)
               OP_ALU:            w_state_next = ST_WB;
               OP_LOAD, OP_STORE: w_state_next = ST_MEM;
               OP_BRANCH: begin
                  pc_load      = branch_taken;
                  pc_increment = ~branch_taken;
                  w_retire     = 1'b1;
               end
               OP_JUMP, OP_JR: begin
                  pc_load  = 1'b1;
                  w_retire = 1'b1;
               end
               OP_JAL: begin
                  pc_load          = 1'b1;
                  reg_write_enable = 1'b1;
                  w_retire         = 1'b1;
               end
               // OP_HALT: park without touching the PC or the retire count
               default: w_state_next = ST_HALT;
            endcase
         end
         ST_MEM: begin
            if (r_op_q == OP_LOAD) begin
               ram_read_enable = 1'b1;
               if (RAM_LAT == 0) begin
                  w_state_next = ST_WB;
               end else begin
                  w_state_next = ST_MWAIT;
                  w_wait_load  = 1'b1;
               end
            end else if (r_op_q == OP_STORE) begin
               ram_write_enable = 1'b1;
               pc_increment     = 1'b1;
               w_retire         = 1'b1;
            end else begin
               // Only loads and stores reach MEM; recover if that ever breaks
               w_state_next = ST_IDLE;
            end
         end
         ST_MWAIT: begin
            w_wait_dec = 1'b1;
            if (w_wait_done) w_state_next = ST_WB;
         end
         ST_WB: begin
            reg_write_enable = 1'b1;
            pc_increment     = 1'b1;
            mem_to_reg       = (r_op_q == OP_LOAD);
            w_retire         = 1'b1;
         end
         ST_HALT: begin
            w_state_next = ST_HALT;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase

      // Every retiring instruction either parks in IDLE (single-step) or
      // goes straight on to the next fetch
      if (w_retire) w_state_next = step ? ST_IDLE : ST_FETCH;
   end

   // State, latched op class and saturating retire counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_op_q        <= OP_ALU;
         r_instr_count <= '0;
      end else begin
         r_state <= w_state_next;
         if (r_state == ST_EXEC) r_op_q <= op_class;
         if (w_retire && (r_instr_count != {CNT_W{1'b1}}))
            r_instr_count <= r_instr_count + CNT_W'(1);
      end
   end

   assign busy        = (r_state != ST_IDLE) && (r_state != ST_HALT);
   assign halted      = (r_state == ST_HALT);
   assign state       = r_state;
   assign instr_count = r_instr_count;

endmodule

// File: doc/cpu_phase_sequencer.md
Name: cpu_phase_sequencer

Overview:
Multi-cycle phase sequencer for the single-issue CPU datapath.
- Steps each instruction through fetch, decode, execute, memory and writeback phases.
- Generates the one-cycle strobes for the PC, ROM instruction register, register file and RAM enables.
- Inserts wait states to cover the synchronous ROM and RAM read latency.
- Supports free-run, single-step and halt, for bring-up on the DE-10 Lite.

Parameters:
- ROM_LAT, 1, ROM read latency in cycles (0..7); sets the FWAIT cycle count.
- RAM_LAT, 1, RAM read latency in cycles (0..7); sets the MWAIT cycle count.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- run  in  1  start/continue request, level-sampled in IDLE
- step  in  1  single-step mode: return to IDLE after each retire
- op_class  in  3  decoded class: 0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 JUMP, 5 JAL, 6 JR, 7 HALT
- branch_taken  in  1  branch condition result, valid in EXEC
- fetch_en  out  1  ROM address valid / fetch strobe
- ir_load  out  1  latch ROM output as the current instruction
- pc_increment  out  1  PC <= PC+1 (retire, sequential)
- pc_load  out  1  PC <= selected target (retire, redirect)
- reg_write_enable  out  1  register file write strobe
- mem_to_reg  out  1  writeback source is RAM
- ram_read_enable  out  1  RAM read strobe
- ram_write_enable  out  1  RAM write strobe
- busy  out  1  high in any state other than IDLE and HALT
- halted  out  1  high in HALT
- state  out  4  current state code, for debug
- instr_count  out  CNT_W  retired instructions, saturating

Behaviour:
- State codes: IDLE=0, FETCH=1, FWAIT=2, DECODE=3, EXEC=4, MEM=5, MWAIT=6, WB=7, HALT=8.
- Reset (async, immediate):
  - state goes to IDLE and instr_count to 0.
  - Every strobe, busy and halted go low.
  - Reset mid-instruction aborts the instruction, including an in-flight RAM write (wren drops at once).
- IDLE: run=1 goes to FETCH next cycle; otherwise hold.
- FETCH: fetch_en=1 for one cycle.
  - Goes to FWAIT with the wait counter loaded to ROM_LAT.
  - If ROM_LAT=0, goes straight to DECODE.
- FWAIT: decrements the counter; goes to DECODE on the cycle the counter reaches 1.
- DECODE: ir_load=1 for one cycle; goes to EXEC.
- EXEC: op_class is latched into op_q. Action by class:
  - ALU: no strobe; goes to WB.
  - LOAD: goes to MEM.
  - STORE: goes to MEM.
  - BRANCH: pc_load=branch_taken and pc_increment=!branch_taken; this cycle is the retire.
  - JUMP, JR: pc_load=1; retire.
  - JAL: pc_load=1 and reg_write_enable=1; retire.
  - HALT: goes to HALT; no PC update; not counted as retired.
- MEM:
  - LOAD: ram_read_enable=1; goes to MWAIT with counter loaded to RAM_LAT, or to WB if RAM_LAT=0.
  - STORE: ram_write_enable=1 and pc_increment=1; retire.
- MWAIT: same countdown as FWAIT; goes to WB.
- WB: reg_write_enable=1, pc_increment=1, mem_to_reg=(op_q==LOAD); retire.
- Retire cycle:
  - instr_count increments, saturating at all-ones.
  - Next state is IDLE if step=1, else FETCH.
- HALT: halted=1; run and step are ignored; exit only by reset.
- Strobe rules:
  - Strobes are decoded from the state register plus op_q.
  - In EXEC only, they depend combinationally on op_class and branch_taken.
  - pc_increment and pc_load are never high together.
  - Each strobe is high for at most one cycle per instruction.
- Latency per instruction at ROM_LAT=RAM_LAT=1:
  - ALU 5 cycles.
  - LOAD 7 cycles.
  - STORE 5 cycles.
  - BRANCH, JUMP, JR, JAL 4 cycles.
- step and run held high together execute one instruction per pass through IDLE, i.e. one extra IDLE cycle between instructions.
- Wait counter width is $clog2(max(ROM_LAT,RAM_LAT)+1).

Decomposition:
- Package cpu_seq_pkg holds:
  - the state enum and its codes,
  - the op_class constants,
  - a function giving the wait-counter width.
- One sub-module, seq_wait_counter: a load/decrement down-counter with a done flag, shared by FWAIT and MWAIT.

Test Plan:
- Reset with run=1, then release → state=0 until the first edge after release, FETCH next; all strobes 0 during reset.
- ALU instruction (op_class=0), step=0, ROM_LAT=1 → fetch_en at cycle 0, ir_load at cycle 2, reg_write_enable+pc_increment at cycle 4, FETCH again at cycle 5, instr_count=1.
- LOAD with RAM_LAT=3 → ram_read_enable at cycle 4, WB at cycle 8 with mem_to_reg=1 and reg_write_enable=1; total 9 cycles.
- BRANCH twice, branch_taken=1 then 0 → first pc_load=1 with pc_increment=0, second pc_increment=1 with pc_load=0; both in the EXEC cycle (cycle 3).
- step=1 with run pulsed once → exactly one instruction retires, state returns to 0, instr_count=1, no further fetch_en until the next run.
- HALT op, then assert run; separately, a STORE with reset asserted in the MEM cycle → HALT case: halted=1, state=8 indefinitely. STORE case: ram_write_enable drops within the same cycle, state=0, instr_count=0.
